uio_bus_scheduler: RTL
======================

// Module: uio_bus_scheduler
// PURPOSE
//  Time-shares the 8-bit bidirectional uio pad bus of tt_um_paolaunisa_top0 between NREQ internal requesters.
//  Round-robin arbitration, burst transfers of 1..MAX_BURST beats, and uio_oe direction control.
//  A turnaround gap is inserted only when the bus direction changes.
//  Sits between the core datapath clients and the uio_in/uio_out/uio_oe top-level pins.
// PARAMETERS
//  NREQ       4  number of requesters (2..8)
//  MAX_BURST  4  max beats per grant; LW = $clog2(MAX_BURST) bits per length field
//  TURN_CYC   1  uio_oe=0 gap cycles inserted on direction change (>=1)
// PORTS
//  clk        in   1        sole clock, rising edge
//  rst        in   1        reset; synchronous, active-high
//  ena        in   1        tile enable; 0 = no new grants
//  req        in   NREQ     request per client; held high until granted
//  req_dir    in   NREQ     1 = drive bus (out), 0 = sample bus (in); sampled at grant
//  req_len    in   NREQ*LW  beats-1 per client; sampled at grant
//  wdata      in   NREQ*8   out-beat data per client (client i at [8i+7:8i])
//  gnt        out  NREQ     one-hot grant, held through TURN and XFER
//  beat       out  1        high on every XFER cycle (data taken / sampled)
//  beat_last  out  1        high on final XFER beat
//  rdata      out  8        registered uio_in of the previous in-beat
//  rdata_vld  out  1        high one cycle after each in-beat
//  busy       out  1        state != IDLE
//  uio_in     in   8        pad input
//  uio_out    out  8        pad output
//  uio_oe     out  8        pad enable: 8'hFF while driving, 8'h00 otherwise
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state=IDLE; gnt=0; beat=0; beat_last=0; rdata=0; rdata_vld=0; busy=0;
//   uio_oe=0; uio_out=0; rr_ptr=NREQ-1 (client 0 wins first); cur_dir=0 (in).
//   Rst mid-transfer aborts at that edge with no further beats.
//  States: IDLE, TURN, XFER.
//  Arbitration happens in IDLE, or on the beat_last cycle of XFER, when ena=1 and |req.
//   - Winner = first set req scanning rr_ptr+1 .. wrapping modulo NREQ.
//   - Latch idx, dir, cnt=req_len[idx]; set gnt one-hot at that edge; rr_ptr<=idx.
//   - If dir != cur_dir: go to TURN for TURN_CYC cycles, then XFER. Otherwise go straight to XFER (zero-gap back-to-back).
//   - cur_dir updates on entry to XFER.
//   - On the beat_last cycle with no winner (or ena=0): go to IDLE next cycle; gnt=0.
//  XFER: beat=1 each cycle; cnt decrements; beat_last=1 when cnt==0; total beats = len+1.
//   - out: uio_oe=8'hFF; uio_out = wdata[idx]. Client advances its data after each cycle with beat=1.
//   - in: uio_oe=0; rdata<=uio_in at the beat edge; rdata_vld=1 on the following cycle.
//  IDLE and TURN: uio_oe=0; uio_out=0; beat=0.
//  gnt, beat, beat_last, busy and uio_oe are registered state decodes.
//  uio_out is a combinational mux of wdata gated by state.
//  req dropped after grant: ignored; the burst completes. req dropped before grant: never granted.
//  ena=0 during TURN/XFER: the current burst completes; no re-grant.
//  Simultaneous requests: resolved only by rr_ptr; no starvation (max wait NREQ-1 bursts).
//  len=0 gives a single beat, with beat and beat_last in the same cycle.
// STRUCTURE
//  Package uio_sched_pkg:
//   - state enum {IDLE,TURN,XFER}
//   - DIR_IN=1'b0, DIR_OUT=1'b1
//   - OE_DRIVE=8'hFF, OE_HIZ=8'h00
//  Sub-module uio_rr_arbiter:
//   - Combinational round-robin pick.
//   - Inputs: req and rr_ptr. Outputs: one-hot win and win_idx.
//  The FSM, counters and muxes stay in this module.
// TESTING
//  1 Hold rst=1 for 2 cycles with req=4'hF -> gnt=0, uio_oe=0, busy=0, beat=0 throughout.
//  2 req[1]=1, dir=out, len=2, wdata[1]=8'hA5, cur_dir=in after reset
//    -> 1 TURN cycle (oe=0, gnt=4'b0010), then 3 beats with oe=FF, uio_out=A5, beat_last on the 3rd, then IDLE.
//  3 req=4'hF, all dir=in, len=0 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles, beat=1 every cycle, no TURN.
//  4 req0 out len0 followed by req1 in len0, uio_in=8'h3C
//    -> beat(oe=FF), TURN(oe=0), beat(oe=0), then rdata=3C with rdata_vld=1 on the next cycle.
//  5 rst pulsed on 2nd beat of a len=3 out burst -> next cycle gnt=0, oe=0, state IDLE; the next grant goes to client 0.
//  6 ena=0 with req=4'h2 -> no grant.
//    ena falls mid-burst -> the burst finishes all beats; no further grant while ena=0.

Source files
------------

// File: rtl/uio_sched_pkg.sv
// rtl/uio_sched_pkg.sv - shared states and encodings for the uio bus scheduler
package uio_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam logic [7:0] OE_DRIVE = 8'hFF;
  localparam logic [7:0] OE_HIZ   = 8'h00;

  function automatic logic [7:0] oe_for(input logic dir);
    return (dir == DIR_OUT) ? OE_DRIVE : OE_HIZ;
  endfunction

endpackage

// File: rtl/uio_rr_arbiter.sv
// rtl/uio_rr_arbiter.sv - combinational round-robin pick starting after rr_ptr
module uio_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx
);

  logic          found;
  logic [IW-1:0] cand;

  // Scan rr_ptr+1 upward, wrapping, so the last winner has lowest priority.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        win_idx   = cand;
        win[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uio_bus_scheduler.sv
// rtl/uio_bus_scheduler.sv - round-robin burst scheduler for the shared uio pad bus
module uio_bus_scheduler
  import uio_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  parameter int TURN_CYC  = 1,
  localparam int LW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_dir,
  input  logic [NREQ*LW-1:0] req_len,
  input  logic [NREQ*8-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic              beat,
  output logic              beat_last,
  output logic [7:0]        rdata,
  output logic              rdata_vld,
  output logic              busy,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] rr_ptr;
  logic          dir;
  logic          cur_dir;
  logic [LW-1:0] cnt;
  logic [TW-1:0] turn_cnt;

  logic [LW-1:0] len_arr   [NREQ];
  logic [7:0]    wdata_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      len_arr[i]   = req_len[i*LW +: LW];
      wdata_arr[i] = wdata[i*8 +: 8];
    end
  end

  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;

  uio_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  logic          win_dir;
  logic [LW-1:0] win_len;
  logic          take_grant;

  // A new grant may start from IDLE or overlap the final beat of a burst.
  always_comb begin
    win_dir    = req_dir[win_idx];
    win_len    = len_arr[win_idx];
    take_grant = ena && (|req) &&
                 ((state == IDLE) || ((state == XFER) && (cnt == '0)));
  end

  assign uio_out = ((state == XFER) && (dir == DIR_OUT)) ? wdata_arr[idx] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      idx       <= '0;
      dir       <= DIR_IN;
      cur_dir   <= DIR_IN;
      cnt       <= '0;
      turn_cnt  <= '0;
      rr_ptr    <= IW'(NREQ - 1);
      beat      <= 1'b0;
      beat_last <= 1'b0;
      busy      <= 1'b0;
      uio_oe    <= OE_HIZ;
      rdata     <= 8'h00;
      rdata_vld <= 1'b0;
    end else begin
      rdata_vld <= 1'b0;
      if ((state == XFER) && (dir == DIR_IN)) begin
        rdata     <= uio_in;
        rdata_vld <= 1'b1;
      end

      if (take_grant) begin
        gnt    <= win;
        idx    <= win_idx;
        dir    <= win_dir;
        cnt    <= win_len;
        rr_ptr <= win_idx;
        busy   <= 1'b1;
        if (win_dir != cur_dir) begin
          state     <= TURN;
          turn_cnt  <= TW'(TURN_CYC - 1);
          beat      <= 1'b0;
          beat_last <= 1'b0;
          uio_oe    <= OE_HIZ;
        end else begin
          state     <= XFER;
          cur_dir   <= win_dir;
          beat      <= 1'b1;
          beat_last <= (win_len == '0);
          uio_oe    <= oe_for(win_dir);
        end
      end else begin
        case (state)
          TURN: begin
            if (turn_cnt == '0) begin
              state     <= XFER;
              cur_dir   <= dir;
              beat      <= 1'b1;
              beat_last <= (cnt == '0);
              uio_oe    <= oe_for(dir);
            end else begin
              turn_cnt <= turn_cnt - 1'b1;
            end
          end
          XFER: begin
            if (cnt == '0) begin
              state     <= IDLE;
              gnt       <= '0;
              beat      <= 1'b0;
              beat_last <= 1'b0;
              busy      <= 1'b0;
              uio_oe    <= OE_HIZ;
            end else begin
              cnt       <= cnt - 1'b1;
              beat_last <= (cnt == LW'(1));
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
